// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
`timescale 1ns/1ps
package fetch_pkg;

    typedef enum logic [1:0] {
        F_REQ   = 2'd0,
        F_VALID = 2'd1,
        F_DRAIN = 2'd2
    } fetch_state_t;

    localparam int          INSTR_W          = 32;
    localparam int          PC_INC           = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Event counters stick at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        if (v == 32'hFFFF_FFFF) begin
            return v;
        end else begin
            return v + 32'd1;
        end
    endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter register: loads either the word-aligned redirect target or pc + PC_INC.
`timescale 1ns/1ps
module pc_reg
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] target_i,
    output logic [ADDR_W-1:0] pc_o
);

    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] pc_q;

    // Next PC: redirect wins; the sequential increment wraps modulo 2^ADDR_W.
    always_comb begin
        if (redirect_i) begin
            pc_d = {target_i[ADDR_W-1:2], 2'b00};
        end else begin
            pc_d = pc_q + ADDR_W'(PC_INC);
        end
    end

    // PC state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q <= RESET_PC;
        end else if (en_i) begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: PC, imem request FSM and decode-facing output registers.
// Optional performance counters are enabled by defining IFETCH_PERF_CNT_EN.
`timescale 1ns/1ps
module ifetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    input  logic               dec_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [15:0]        imm16,
    output logic [ADDR_W-1:0]  pc_out,
    output logic [ADDR_W-1:0]  pc_plus4,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_target
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [31:0]        fetch_cnt,
    output logic [31:0]        stall_cnt
`endif
);

    fetch_state_t       state_d, state_q;
    logic [INSTR_W-1:0] instr_d, instr_q;
    logic               instr_valid_d, instr_valid_q;
    logic               imem_req_d, imem_req_q;
    logic               pc_en_s;
    logic [ADDR_W-1:0]  pc_s;

    assign pc_en_s = redirect_valid | ((state_q == F_VALID) & dec_ready);

    pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk_i      (clk),
        .rst_i      (reset),
        .en_i       (pc_en_s),
        .redirect_i (redirect_valid),
        .target_i   (redirect_target),
        .pc_o       (pc_s)
    );

    // Fetch FSM next state and instruction capture.
    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        case (state_q)
            F_REQ: begin
                if (redirect_valid) begin
                    // Only an issued request leaves a response in flight that must be drained.
                    if (imem_rvalid || !imem_req_q) begin
                        state_d = F_REQ;
                    end else begin
                        state_d = F_DRAIN;
                    end
                end else if (imem_rvalid) begin
                    instr_d = imem_rdata;
                    state_d = F_VALID;
                end else begin
                    state_d = F_REQ;
                end
            end
            F_VALID: begin
                if (redirect_valid || dec_ready) begin
                    state_d = F_REQ;
                end else begin
                    state_d = F_VALID;
                end
            end
            F_DRAIN: begin
                if (imem_rvalid) begin
                    state_d = F_REQ;
                end else begin
                    state_d = F_DRAIN;
                end
            end
            default: begin
                state_d = F_REQ;
            end
        endcase
        instr_valid_d = (state_d == F_VALID);
        imem_req_d    = (state_d == F_REQ);
    end

    // State and output registers; imem_req stays low while reset is applied.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= F_REQ;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            imem_req_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            imem_req_q    <= imem_req_d;
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = pc_s;
    assign instr_valid = instr_valid_q;
    assign instr       = instr_q;
    assign imm16       = instr_q[15:0];
    assign pc_out      = pc_s;
    assign pc_plus4    = pc_s + ADDR_W'(PC_INC);

`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_d, fetch_cnt_q;
    logic [31:0] stall_cnt_d, stall_cnt_q;

    // Handed-over instructions and non-VALID cycles.
    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (instr_valid_q && dec_ready) begin
            fetch_cnt_d = sat_inc32(fetch_cnt_q);
        end else begin
            fetch_cnt_d = fetch_cnt_q;
        end
        if (state_q != F_VALID) begin
            stall_cnt_d = sat_inc32(stall_cnt_q);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_cnt_q <= 32'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Randomized scoreboard bench for ifetch_unit; the imem model and program-order PC model live here.
`timescale 1ns/1ps
module tb_ifetch_unit;

    localparam logic [31:0] TB_RESET_PC = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        instr_valid;
    logic        dec_ready = 1'b0;
    logic [31:0] instr;
    logic [15:0] imm16;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = 32'd0;
`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;
`endif

    ifetch_unit #(
        .ADDR_W   (32),
        .RESET_PC (TB_RESET_PC)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_rvalid     (imem_rvalid),
        .imem_rdata      (imem_rdata),
        .instr_valid     (instr_valid),
        .dec_ready       (dec_ready),
        .instr           (instr),
        .imm16           (imm16),
        .pc_out          (pc_out),
        .pc_plus4        (pc_plus4),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target)
`ifdef IFETCH_PERF_CNT_EN
        ,
        .fetch_cnt       (fetch_cnt),
        .stall_cnt       (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;

    // Reference model state
    logic [31:0] exp_pc = TB_RESET_PC;
    logic [31:0] fetch_m = 32'd0;
    logic [31:0] stall_m = 32'd0;
    bit          busy = 1'b0;
    bit          killed = 1'b0;
    bit          accept_en = 1'b1;
    bit          exp_iv_next = 1'b0;
    int          cnt = 0;
    logic [31:0] req_addr = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // One clock cycle of stimulus; entered and left at posedge+1.
    task automatic step(input bit redir, input logic [31:0] tgt, input bit rdy,
                        input int dly, input logic [31:0] word);
        bit iv;
        iv = instr_valid;
        if (exp_iv_next) chk("fetch_latency", {31'd0, iv}, 32'd1);
        exp_iv_next = 1'b0;
`ifdef IFETCH_PERF_CNT_EN
        chk("fetch_cnt", fetch_cnt, fetch_m);
        chk("stall_cnt", stall_cnt, stall_m);
`endif
        if (!busy && imem_req && accept_en) begin
            busy     = 1'b1;
            killed   = 1'b0;
            req_addr = imem_addr;
            cnt      = dly;
            chk("imem_addr", imem_addr, exp_pc);
        end
        redirect_valid  = redir;
        redirect_target = tgt;
        dec_ready       = rdy;
        imem_rvalid     = 1'b0;
        imem_rdata      = $urandom;
        if (busy) begin
            if (redir) killed = 1'b1;
            if (cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = word;
                busy        = 1'b0;
                if (!killed) begin
                    sb_q.push_back('{pc: req_addr, word: word});
                    exp_iv_next = 1'b1;
                end
            end else begin
                cnt--;
            end
        end
        if (redir)           exp_pc = tgt & 32'hFFFF_FFFC;
        else if (iv && rdy)  exp_pc = exp_pc + 32'd4;
        if (iv && rdy)       fetch_m = fetch_m + 32'd1;
        if (!iv)             stall_m = stall_m + 32'd1;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_free();
        for (int i = 0; i < 20 && !(imem_req && !busy); i++) step(1'b0, 32'd0, 1'b1, 0, $urandom);
        chk("wait_free_timeout", {31'd0, imem_req && !busy}, 32'd1);
    endtask

    // Monitor: presentation, hold stability and drop behaviour to decode.
    bit   prev_iv = 1'b0, prev_rdy = 1'b0, prev_redir = 1'b0;
    exp_t cur = '0;
    always @(negedge clk) begin
        if (!reset) begin
            if (prev_iv) begin
                if (prev_rdy || prev_redir) chk("valid_drop", {31'd0, instr_valid}, 32'd0);
                else                        chk("valid_hold", {31'd0, instr_valid}, 32'd1);
            end
            if (instr_valid) begin
                if (!prev_iv) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL spurious_instr actual=%h required=none", instr);
                    end else begin
                        cur = sb_q.pop_front();
                        chk("instr", instr, cur.word);
                        chk("pc_out", pc_out, cur.pc);
                        chk("pc_plus4", pc_plus4, cur.pc + 32'd4);
                        chk("imm16", {16'd0, imm16}, {16'd0, cur.word[15:0]});
                    end
                end else begin
                    chk("hold_instr", instr, cur.word);
                    chk("hold_pc", pc_out, cur.pc);
                    chk("hold_imm16", {16'd0, imm16}, {16'd0, cur.word[15:0]});
                end
                chk("no_req_in_valid", {31'd0, imem_req}, 32'd0);
            end
            prev_iv    = instr_valid;
            prev_rdy   = dec_ready;
            prev_redir = redirect_valid;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] tgt;
        int          r;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
        chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_pc", pc_out, TB_RESET_PC);
`ifdef IFETCH_PERF_CNT_EN
        chk("rst_fetch_cnt", fetch_cnt, 32'd0);
        chk("rst_stall_cnt", stall_cnt, 32'd0);
`endif
        reset = 1'b0;

        // Back-to-back fetch across the address wrap
        repeat (12) step(1'b0, 32'd0, 1'b1, 0, $urandom);

        // Hold one instruction with decode stalled
        wait_free();
        repeat (8) step(1'b0, 32'd0, 1'b0, 0, 32'h2008_FFFF);
        step(1'b0, 32'd0, 1'b1, 0, $urandom);

        // Redirect while an instruction is held
        for (int i = 0; i < 20 && !instr_valid; i++) step(1'b0, 32'd0, 1'b0, 0, $urandom);
        chk("reach_valid", {31'd0, instr_valid}, 32'd1);
        step(1'b1, 32'h0000_0103, 1'b0, 0, $urandom);
        repeat (4) step(1'b0, 32'd0, 1'b1, 0, $urandom);

        // Redirect in REQ with the response three cycles later
        wait_free();
        step(1'b0, 32'd0, 1'b1, 3, $urandom);
        step(1'b1, 32'h0000_4444, 1'b1, 0, $urandom);
        repeat (8) step(1'b0, 32'd0, 1'b1, 0, $urandom);

        // Redirect coincident with the response
        wait_free();
        step(1'b1, 32'h0000_8882, 1'b1, 0, $urandom);
        repeat (4) step(1'b0, 32'd0, 1'b1, 0, $urandom);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 3);
            tgt = (r == 0) ? 32'hFFFF_FFFE : $urandom;
            r = $urandom_range(0, 7);
            step(($urandom_range(0, 9) == 0), tgt, ($urandom_range(0, 9) < 7),
                 (r < 4) ? 0 : r - 3, $urandom);
        end

        // Drain: stop accepting requests and let the last word reach decode
        accept_en = 1'b0;
        for (int i = 0; i < 10 && busy; i++) step(1'b0, 32'd0, 1'b1, 0, $urandom);
        repeat (4) step(1'b0, 32'd0, 1'b1, 0, $urandom);
        chk("scoreboard_empty", sb_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
